// File: rtl/tdc_hit_capture_ctrl.sv
// Capture sequencer for the CARRY4 start delay line: arms the line, grabs the
// synchronised thermometer on a hit, ones-counts it and issues a timestamp.
module tdc_hit_capture_ctrl #(
  parameter int unsigned NCARRY4     = 46,
  parameter int unsigned COARSE_W    = 16,
  parameter int unsigned FINE_W      = 8,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*NCARRY4-1:0]  taps,
  output logic                  arm,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic [COARSE_W-1:0]   ts_coarse,
  output logic [FINE_W-1:0]     ts_fine,
  output logic                  ts_sat,
  output logic                  busy
);

  localparam int unsigned NTAP   = 4 * NCARRY4;
  localparam int unsigned DEAD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ENCODE,
    OUTPUT,
    DEAD
  } state_t;

  state_t              state;
  logic [NTAP-1:0]     s1, s2, cap;
  logic [COARSE_W-1:0] coarse, c1, c2, cap_coarse;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [FINE_W-1:0]   pop;

  // Two-stage tap synchroniser; c2 tracks the coarse value seen when s1 sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else begin
      s1 <= taps;
      s2 <= s1;
      c1 <= coarse;
      c2 <= c1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coarse <= '0;
    end else if (enable) begin
      coarse <= coarse + COARSE_W'(1);
    end
  end

  // Ones count of the captured thermometer; bubbles simply don't contribute.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NTAP); i++) begin
      pop = pop + FINE_W'(cap[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arm        <= 1'b0;
      ts_valid   <= 1'b0;
      ts_coarse  <= '0;
      ts_fine    <= '0;
      ts_sat     <= 1'b0;
      busy       <= 1'b0;
      cap        <= '0;
      cap_coarse <= '0;
      dead_cnt   <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      arm      <= 1'b0;
      ts_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= DEAD;
          busy     <= 1'b1;
          dead_cnt <= DEAD_W'(DEAD_CYCLES);
        end
        ARMED: begin
          if (s2[0]) begin
            cap        <= s2;
            cap_coarse <= c2;
            arm        <= 1'b0;
            state      <= ENCODE;
          end
        end
        ENCODE: begin
          ts_fine   <= pop;
          ts_sat    <= &cap;
          ts_coarse <= cap_coarse;
          ts_valid  <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (ts_ready) begin
            ts_valid <= 1'b0;
            dead_cnt <= DEAD_W'(DEAD_CYCLES);
            state    <= DEAD;
          end
        end
        DEAD: begin
          if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
          end
          // Re-arm only once the hold-off has expired and the chain has drained.
          if ((dead_cnt <= DEAD_W'(1)) && (s2 == '0)) begin
            arm   <= 1'b1;
            state <= ARMED;
          end
        end
        default: begin
          state <= IDLE;
          arm   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
